// File: rtl/schommel_aandrijving.sv
`default_nettype none
// ============================================================================
// Module   : schommel_aandrijving
// Purpose  : Rocking-drive waveform generator. It turns the amplitude A and
//            the frequency step F into a signed cradle position, a direction
//            bit and a PWM drive. New A/F values are taken over only at a
//            centre crossing of the swing. F = 0 parks the cradle at centre.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            A[3:0]     - requested amplitude 0..15
//            F[3:0]     - requested frequency step 0..15 (0 = stop)
//            pos[7:0]   - signed cradle position, -120..119
//            dir        - 1 when pos < 0
//            pwm        - motor PWM, duty |pos|/128
//            at_center  - 1 when pos is 0 or -1
//            update_ack - one-cycle pulse when active A/F change
// Options  : SCHOMMEL_SOFTSTART_EN - when defined, A_act walks one step per
//            apply toward the requested amplitude.
// Revision : 1.0 - initial release
// ============================================================================
module schommel_aandrijving #(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] F,
    output logic [7:0] pos,
    output logic       dir,
    output logic       pwm,
    output logic       at_center,
    output logic       update_ack
);

    localparam int                 c_DIV_W     = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [11:0]        c_PHASE_POS = 12'h400;
    localparam logic [11:0]        c_PHASE_NEG = 12'hC00;
    localparam logic [0:0]         c_STOPPED   = 1'b0;
    localparam logic [0:0]         c_SWINGING  = 1'b1;

    logic [3:0]         r_a_req;
    logic [3:0]         r_f_req;
    logic [3:0]         r_a_act;
    logic [3:0]         r_f_act;
    logic [c_DIV_W-1:0] r_div;
    logic [11:0]        r_phase;
    logic [0:0]         r_state;
    logic [6:0]         r_pc;
    logic               r_pwm;
    logic               r_ack;

    logic [0:0]         w_state_nxt;
    logic               w_tick;
    logic [11:0]        w_phase_adv;
    logic               w_neg_now;
    logic               w_neg_adv;
    logic               w_cross;
    logic               w_apply;
    logic               w_snap;
    logic [3:0]         w_a_new;
    logic [7:0]         w_t;
    logic [7:0]         w_s;
    logic signed [11:0] w_s_ext;
    logic signed [11:0] w_a_ext;
    logic signed [11:0] w_prod;
    logic [7:0]         w_mag;
    logic               w_unused;

    // Input stage: A/F are sampled every cycle; only the value present at
    // the apply tick is ever used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_req <= 4'd0;
            r_f_req <= 4'd0;
        end else begin
            r_a_req <= A;
            r_f_req <= F;
        end
    end

    // Motion-tick prescaler
    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // The sign of the triangle is set by the phase quadrant: the negative
    // half covers 0xC00..0x3FF (wrapping), so the 0xFFF->0x000 wrap never
    // changes sign.
    assign w_phase_adv = r_phase + {8'd0, r_f_act};
    assign w_neg_now   = ~(r_phase[11] ^ r_phase[10]);
    assign w_neg_adv   = ~(w_phase_adv[11] ^ w_phase_adv[10]);
    assign w_cross     = w_neg_now ^ w_neg_adv;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_apply) begin
            w_state_nxt = (r_f_req != 4'd0) ? c_SWINGING : c_STOPPED;
        end
    end

    // State outputs: when stopped every tick applies; when swinging only a
    // centre-crossing tick does. Stopping snaps the phase onto the centre.
    always_comb begin
        w_apply = 1'b0;
        w_snap  = 1'b0;
        case (r_state)
            c_STOPPED: begin
                w_apply = w_tick;
            end
            c_SWINGING: begin
                w_apply = w_tick && w_cross;
                w_snap  = w_tick && w_cross && (r_f_req == 4'd0);
            end
            default: begin
                w_apply = 1'b0;
                w_snap  = 1'b0;
            end
        endcase
    end

`ifdef SCHOMMEL_SOFTSTART_EN
    always_comb begin
        w_a_new = r_a_act;
        if (r_a_req > r_a_act) begin
            w_a_new = r_a_act + 4'd1;
        end else if (r_a_req < r_a_act) begin
            w_a_new = r_a_act - 4'd1;
        end
    end
`else
    assign w_a_new = r_a_req;
`endif

    // Phase accumulator and active amplitude/frequency registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= c_PHASE_POS;
            r_a_act <= 4'd0;
            r_f_act <= 4'd0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_tick) begin
                if (w_snap) begin
                    r_phase <= w_phase_adv[11] ? c_PHASE_NEG : c_PHASE_POS;
                end else begin
                    r_phase <= w_phase_adv;
                end
            end
            if (w_apply) begin
                r_a_act <= w_a_new;
                r_f_act <= r_f_req;
                r_ack   <= (w_a_new != r_a_act) || (r_f_req != r_f_act);
            end
        end
    end

    // Triangle t in 0..255; s = t - 128 is t with its MSB inverted
    assign w_t     = r_phase[11] ? ~r_phase[10:3] : r_phase[10:3];
    assign w_s     = {~w_t[7], w_t[6:0]};
    assign w_s_ext = {{4{w_s[7]}}, w_s};
    assign w_a_ext = {8'd0, r_a_act};
    assign w_prod  = w_s_ext * w_a_ext;

    // Taking bits [11:4] of the product is the arithmetic shift by 4
    assign pos       = w_prod[11:4];
    assign dir       = pos[7];
    assign at_center = (pos == 8'h00) || (pos == 8'hFF);
    assign w_mag     = pos[7] ? (8'd0 - pos) : pos;
    assign w_unused  = ^w_prod[3:0];

    // PWM against a free-running 7-bit ramp
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= 7'd0;
            r_pwm <= 1'b0;
        end else begin
            r_pc  <= r_pc + 7'd1;
            r_pwm <= ({1'b0, r_pc} < w_mag);
        end
    end

    assign pwm        = r_pwm;
    assign update_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_schommel_aandrijving.sv
`default_nettype none
// ============================================================================
// Module   : tb_schommel_aandrijving
// Purpose  : Self-checking bench for schommel_aandrijving with a tick-level
//            integer reference model of phase, amplitude and apply rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_schommel_aandrijving;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] A;
    logic [3:0] F;
    logic [7:0] pos;
    logic       dir;
    logic       pwm;
    logic       at_center;
    logic       update_ack;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_phase, m_aact, m_fact, m_areq, m_freq, m_cnt, m_pc;
    bit m_pwm, m_ack;
    longint cyc = 0;

    schommel_aandrijving #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .F          (F),
        .pos        (pos),
        .dir        (dir),
        .pwm        (pwm),
        .at_center  (at_center),
        .update_ack (update_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // triangle value s in -128..127 from a 12-bit phase
    function automatic int tri_s(int p);
        int t;
        t = (p < 2048) ? (p / 8) : (255 - (p - 2048) / 8);
        return t - 128;
    endfunction

    function automatic int model_pos(int p, int a);
        return (tri_s(p) * a) >>> 4;
    endfunction

    function automatic logic [11:0] exp_vec();
        int p;
        p = model_pos(m_phase, m_aact);
        return {8'(p), (p < 0), (p == 0 || p == -1), m_pwm, m_ack};
    endfunction

    task automatic model_reset();
        m_phase = 1024; m_aact = 0; m_fact = 0; m_areq = 0; m_freq = 0;
        m_cnt = 0; m_pc = 0; m_pwm = 0; m_ack = 0;
    endtask

    // advance one clock and the model with it
    task automatic step();
        int adv, sb, sa, newa, p;
        bit tick, nack, npwm;
        @(posedge clk);
        cyc++;
        p    = model_pos(m_phase, m_aact);
        npwm = (m_pc < ((p < 0) ? -p : p));
        nack = 0;
        tick = (m_cnt == DIV - 1);
        if (tick) begin
            adv = (m_phase + m_fact) % 4096;
            sb  = tri_s(m_phase);
            sa  = tri_s(adv);
            if (m_fact == 0 || ((sb < 0) != (sa < 0))) begin
`ifdef SCHOMMEL_SOFTSTART_EN
                newa = (m_areq > m_aact) ? m_aact + 1 :
                       (m_areq < m_aact) ? m_aact - 1 : m_aact;
`else
                newa = m_areq;
`endif
                nack = (newa != m_aact) || (m_freq != m_fact);
                if (m_freq == 0 && m_fact != 0)
                    adv = (adv < 2048) ? 1024 : 3072;
                m_aact = newa;
                m_fact = m_freq;
            end
            m_phase = adv;
        end
        m_cnt  = tick ? 0 : m_cnt + 1;
        m_pc   = (m_pc + 1) % 128;
        m_pwm  = npwm;
        m_ack  = nack;
        m_areq = int'(A);
        m_freq = int'(F);
        #1;
    endtask

    task automatic test_reset();
        int acks;
        A = 4'd0; F = 4'd0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pos, dir, at_center, pwm, update_ack} !== 12'h004) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", {pos, dir, at_center, pwm, update_ack}, 12'h004);
        end
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            acks += int'(update_ack);
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL idle cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL idle_no_ack: got %0d pulses want 0", acks);
        end
    endtask

    task automatic test_swing();
        int maxp, minp, acks, prev, cur, c1, c2;
        A = 4'd15; F = 4'd8;
        maxp = -1000; minp = 1000; acks = 0; prev = 0; c1 = -1; c2 = -1;
        for (int i = 0; i < 4700; i++) begin
            step();
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL swing cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
            cur = $signed(pos);
            acks += int'(update_ack);
            if (cur > maxp) maxp = cur;
            if (cur < minp) minp = cur;
            if (prev < 0 && cur >= 0) begin
                if (c1 < 0) c1 = i;
                else if (c2 < 0) c2 = i;
            end
            prev = cur;
        end
`ifndef SCHOMMEL_SOFTSTART_EN
        checks++;
        if (maxp !== 119) begin
            errors++;
            $display("FAIL swing_peak: got %0d want 119", maxp);
        end
        checks++;
        if (minp !== -120) begin
            errors++;
            $display("FAIL swing_trough: got %0d want -120", minp);
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL swing_acks: got %0d want 1", acks);
        end
        checks++;
        if ((c2 - c1) !== 2048) begin
            errors++;
            $display("FAIL swing_period: got %0d clk want 2048", c2 - c1);
        end
`endif
    endtask

    task automatic test_freq_change();
        int acks, prev, cur, c1, c2, i;
        F = 4'd4;
        acks = 0; prev = $signed(pos); c1 = -1; c2 = -1;
        i = 0;
        while (c2 < 0 && i < 12000) begin
            step();
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL fchange cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
            cur = $signed(pos);
            acks += int'(update_ack);
            if (acks > 0 && prev < 0 && cur >= 0) begin
                if (c1 < 0) c1 = i;
                else c2 = i;
            end
            prev = cur;
            i++;
        end
        checks++;
        if (c2 < 0) begin
            errors++;
            $display("FAIL fchange_budget: got %0d crossings want 2", (c1 < 0) ? 0 : 1);
        end
`ifndef SCHOMMEL_SOFTSTART_EN
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL fchange_acks: got %0d want 1", acks);
        end
        checks++;
        if ((c2 - c1) !== 4096) begin
            errors++;
            $display("FAIL fchange_period: got %0d clk want 4096", c2 - c1);
        end
`endif
    endtask

    task automatic test_stop();
        int i;
        logic [7:0] held;
        F = 4'd0;
        i = 0;
        while (m_fact != 0 && i < 3000) begin
            step();
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL stop cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
            i++;
        end
        checks++;
        if (m_fact != 0) begin
            errors++;
            $display("FAIL stop_budget: model F_act %0d want 0", m_fact);
        end
        held = 8'(model_pos(m_phase, m_aact));
        for (int k = 0; k < 300; k++) begin
            step();
            checks++;
            if ({pos, at_center} !== {held, 1'b1}) begin
                errors++;
                $display("FAIL stop_parked cyc %0d: got pos %h ctr %b want pos %h ctr 1", cyc, pos, at_center, held);
            end
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL stop_model cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            A = 4'($urandom_range(0, 15));
            F = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 250);
            for (int k = 0; k < hold; k++) begin
                step();
                checks++;
                if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                    errors++;
                    $display("FAIL random cyc %0d A %0d F %0d: got %h want %h", cyc, A, F, {pos, dir, at_center, pwm, update_ack}, exp_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid_swing();
        int i;
        A = 4'd15; F = 4'd8;
        i = 0;
        while (model_pos(m_phase, m_aact) < 100 && i < 6000) begin
            step();
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_run cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
            i++;
        end
        checks++;
        if (model_pos(m_phase, m_aact) < 100) begin
            errors++;
            $display("FAIL midrst_budget: model pos %0d want >= 100", model_pos(m_phase, m_aact));
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({pos, dir, at_center, pwm, update_ack} !== 12'h004) begin
            errors++;
            $display("FAIL midrst_async: got %h want %h", {pos, dir, at_center, pwm, update_ack}, 12'h004);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pos, dir, at_center, pwm, update_ack} !== 12'h004) begin
            errors++;
            $display("FAIL midrst_hold: got %h want %h", {pos, dir, at_center, pwm, update_ack}, 12'h004);
        end
        reset = 1'b1;
        for (int k = 0; k < 600; k++) begin
            step();
            checks++;
            if ({pos, dir, at_center, pwm, update_ack} !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_restart cyc %0d: got %h want %h", cyc, {pos, dir, at_center, pwm, update_ack}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_swing();
        test_freq_change();
        test_stop();
        test_random();
        test_reset_mid_swing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
